// File: rtl/cordic_result_collector.sv
// cordic_result_collector
// Follows each accepted issue through the fixed latency of the 29-iteration
// CORDIC rotator. It captures x/y on the edge where the rotator output is
// valid and buffers the results in a small first-word-fall-through FIFO.
// Issue credit is granted only when every in-flight result is sure to find a
// FIFO slot.
// Optional feature: define CORDIC_GAIN_COMP_EN to multiply the captured
// results by GAIN_Q24 (Q8.24) with rounding and saturation. When the macro is
// undefined, results pass through unmodified.
//
// Handshakes: issue_valid is an accepted issue only on a rising edge where
// issue_ready is high. A result leaves the FIFO on a rising edge where
// out_valid && out_ready. The head (out_cos/out_sin) holds stable while
// out_valid && !out_ready.
module cordic_result_collector #(
  parameter int LATENCY    = 30,
  parameter int FIFO_DEPTH = 4,
  parameter int GAIN_Q24   = 10188012
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  output logic                         issue_ready,
  input  logic [31:0]                  cordic_x,
  input  logic [31:0]                  cordic_y,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [31:0]                  out_cos,
  output logic [31:0]                  out_sin,
  output logic [$clog2(LATENCY+1)-1:0] inflight,
  output logic                         overflow_err
);

  localparam int IW = $clog2(LATENCY + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  // Elaboration-time parameter sanity checks.
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (GAIN_Q24 <= 0) begin : g_bad_gain
    $error("GAIN_Q24 must be positive");
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [63:0] GAIN_S  = 64'(GAIN_Q24);
  localparam logic signed [63:0] SAT_MAX = 64'sd2147483647;
  localparam logic signed [63:0] SAT_MIN = -64'sd2147483648;

  // Q8.24 x Q8.24 product, rounded to nearest and saturated to 32 bits.
  function automatic logic [31:0] gain_comp(input logic [31:0] v);
    logic signed [63:0] prod;
    logic signed [63:0] scaled;
    prod   = 64'(signed'(v)) * GAIN_S;
    scaled = (prod + 64'sd8388608) >>> 24;
    if (scaled > SAT_MAX)      return 32'h7FFF_FFFF;
    else if (scaled < SAT_MIN) return 32'h8000_0000;
    else                       return scaled[31:0];
  endfunction
`else
  // Compensation disabled: the raw rotator value is stored.
  function automatic logic [31:0] gain_comp(input logic [31:0] v);
    return v;
  endfunction
`endif

  logic [LATENCY-1:0] vsr;
  logic [31:0]        mem_cos [FIFO_DEPTH];
  logic [31:0]        mem_sin [FIFO_DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [CW-1:0]      count;

  logic accept;
  logic capture;
  logic pop;
  logic full;
  logic push;
  logic drop;
  logic [31:0] wr_cos;
  logic [31:0] wr_sin;

  // Credit covers in-flight work plus stored work. It deliberately ignores a
  // same-cycle pop, which keeps the rule conservative.
  assign issue_ready = (32'(inflight) + 32'(count)) < 32'(FIFO_DEPTH);
  assign accept      = issue_valid && issue_ready;
  assign capture     = vsr[LATENCY-1];
  assign out_valid   = count != '0;
  assign pop         = out_valid && out_ready;
  assign full        = count == CW'(FIFO_DEPTH);
  assign push        = capture && (!full || pop);
  assign drop        = capture && full && !pop;
  assign wr_cos      = gain_comp(cordic_x);
  assign wr_sin      = gain_comp(cordic_y);
  assign out_cos     = out_valid ? mem_cos[rd_ptr] : '0;
  assign out_sin     = out_valid ? mem_sin[rd_ptr] : '0;

  // Valid tracking, in-flight counter, FIFO pointers/count, and sticky error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr          <= '0;
      inflight     <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      vsr <= {vsr[LATENCY-2:0], accept};
      if (accept && !capture)      inflight <= inflight + IW'(1);
      else if (!accept && capture) inflight <= inflight - IW'(1);
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
      if ((issue_valid && !issue_ready) || drop) overflow_err <= 1'b1;
    end
  end

  // FIFO storage. Unread entries are masked by count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_cos[wr_ptr] <= wr_cos;
      mem_sin[wr_ptr] <= wr_sin;
    end
  end

endmodule

// File: tb/tb_cordic_result_collector.sv
// tb_cordic_result_collector
// A stub rotator delays each issue's {x,y} by exactly LAT edges and drives
// random data on every other cycle. A queue model of issues and buffered
// results supplies the expected outputs, which are compared every negedge
// for the default-gain instance and for a gain=2.0 instance. Directed tests
// add hand-computed literal checks.
module tb_cordic_result_collector;
  localparam int     LAT   = 30;
  localparam int     DEPTH = 4;
  localparam longint G_DEF = 10188012;
  localparam longint G_SAT = 33554432;

  // ---------------- clock / reset / signals ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        issue_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] cordic_x = '0;
  logic [31:0] cordic_y = '0;
  logic        issue_ready, out_valid, overflow_err;
  logic [31:0] out_cos, out_sin;
  logic [4:0]  inflight;
  logic        s_issue_ready, s_out_valid, s_overflow_err;
  logic [31:0] s_cos, s_sin;
  logic [4:0]  s_inflight;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cordic_result_collector u_dut (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .out_valid(out_valid),
    .out_ready(out_ready), .out_cos(out_cos), .out_sin(out_sin),
    .inflight(inflight), .overflow_err(overflow_err)
  );

  cordic_result_collector #(.GAIN_Q24(33554432)) u_sat (
    .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_ready(s_issue_ready),
    .cordic_x(cordic_x), .cordic_y(cordic_y), .out_valid(s_out_valid),
    .out_ready(out_ready), .out_cos(s_cos), .out_sin(s_sin),
    .inflight(s_inflight), .overflow_err(s_overflow_err)
  );

  // ---------------- stub rotator ----------------
  logic [31:0] iss_x = '0;
  logic [31:0] iss_y = '0;
  logic [63:0] pipe [LAT];

  initial for (int k = 0; k < LAT; k++) pipe[k] = '0;

  always begin
    @(posedge clk);
    #1;
    for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
    pipe[0]  = issue_valid ? {iss_x, iss_y} : {$urandom, $urandom};
    cordic_x = pipe[LAT-1][63:32];
    cordic_y = pipe[LAT-1][31:0];
  end

  // ---------------- model ----------------
  function automatic logic [31:0] comp(input logic [31:0] v, input longint g);
`ifdef CORDIC_GAIN_COMP_EN
    longint r;
    r = (longint'($signed(v)) * g + 64'sd8388608) >>> 24;
    if (r > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (r < -64'sd2147483648) return 32'h8000_0000;
    return r[31:0];
`else
    if (g == 0) return v;
    return v;
`endif
  endfunction

  logic [95:0]  iss_q[$];   // {issue cycle, x, y}
  logic [127:0] exp_q[$];   // {cos, sin, sat_cos, sat_sin}
  int cyc = 0;
  bit m_ovf = 1'b0;

  always @(posedge clk or posedge rst) begin : model
    bit ready_now, pop_now, cap_now;
    logic [95:0] h;
    if (rst) begin
      iss_q.delete();
      exp_q.delete();
      m_ovf = 1'b0;
    end else begin
      ready_now = (iss_q.size() + exp_q.size()) < DEPTH;
      pop_now   = (exp_q.size() != 0) && out_ready;
      cap_now   = (iss_q.size() != 0) && (int'(iss_q[0][95:64]) + LAT == cyc);
      if (pop_now) void'(exp_q.pop_front());
      if (cap_now) begin
        h = iss_q.pop_front();
        if (exp_q.size() < DEPTH)
          exp_q.push_back({comp(h[63:32], G_DEF), comp(h[31:0], G_DEF),
                           comp(h[63:32], G_SAT), comp(h[31:0], G_SAT)});
        else
          m_ovf = 1'b1;
      end
      if (issue_valid) begin
        if (ready_now) iss_q.push_back({32'(cyc), iss_x, iss_y});
        else           m_ovf = 1'b1;
      end
      cyc++;
    end
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic chk_tol(input string name, input logic [31:0] act, input int exp, input int tol);
    longint d;
    d = longint'($signed(act)) - longint'(exp);
    n_checks++;
    if (d >= -tol && d <= tol) n_pass++;
    else $display("FAIL %s: got %0d expected %0d +/- %0d", name, $signed(act), exp, tol);
  endtask

  // Compare process: every negedge against the model.
  always @(negedge clk) begin : compare
    logic [127:0] e;
    chk("issue_ready", issue_ready, (iss_q.size() + exp_q.size()) < DEPTH);
    chk("out_valid", out_valid, exp_q.size() != 0);
    chk("inflight", inflight, iss_q.size());
    chk("overflow_err", overflow_err, m_ovf);
    chk("sat_issue_ready", s_issue_ready, (iss_q.size() + exp_q.size()) < DEPTH);
    chk("sat_out_valid", s_out_valid, exp_q.size() != 0);
    chk("sat_inflight", s_inflight, iss_q.size());
    chk("sat_overflow_err", s_overflow_err, m_ovf);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk("out_cos", out_cos, e[127:96]);
      chk("out_sin", out_sin, e[95:64]);
      chk("sat_cos", s_cos, e[63:32]);
      chk("sat_sin", s_sin, e[31:0]);
    end else begin
      chk("out_cos_idle", out_cos, 0);
      chk("out_sin_idle", out_sin, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic single(input logic [31:0] x, input logic [31:0] y, output int lat);
    iss_x = x;
    iss_y = y;
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  // ---------------- directed tests ----------------
  initial begin : main
    int lat, acc, nv;
    logic [31:0] ax, ay, e1, e2;
    int tc, ts;

    #1 rst = 1'b1;
    repeat (3) tick();
    chk("rst_issue_ready", issue_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_cos", out_cos, 0);
    chk("rst_out_sin", out_sin, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_overflow", overflow_err, 0);
    rst = 1'b0;
    tick();

    // 30 degree rotation, single issue.
`ifdef CORDIC_GAIN_COMP_EN
    ax = 32'd23926595; ay = 32'd13814027; tc = 14529495; ts = 8388608;
`else
    ax = 32'd23926827; ay = 32'd13814065; tc = 23926827; ts = 13814065;
`endif
    out_ready = 1'b1;
    single(ax, ay, lat);
    chk("t30_latency", lat, 30);
    chk_tol("t30_cos", out_cos, tc, 64);
    chk_tol("t30_sin", out_sin, ts, 64);
    chk("t30_inflight", inflight, 0);
    repeat (3) tick();

    // Back-to-back with the consumer stalled.
    out_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      iss_x = 32'h0100_0000 * 32'(i + 1);
      iss_y = 32'h0 - iss_x;
      issue_valid = issue_ready;
      if (issue_ready) acc++;
      tick();
    end
    issue_valid = 1'b0;
    chk("b2b_accepts", acc, 4);
    chk("b2b_ready_low", issue_ready, 0);
    repeat (35) tick();
`ifdef CORDIC_GAIN_COMP_EN
    e1 = 32'd10188012; e2 = 32'd20376024;
`else
    e1 = 32'h0100_0000; e2 = 32'h0200_0000;
`endif
    chk("b2b_buffered", out_valid, 1);
    chk("b2b_ready_still_low", issue_ready, 0);
    chk("b2b_head", out_cos, e1);
    out_ready = 1'b1;
    tick();
    chk("b2b_second", out_cos, e2);
    repeat (3) tick();
    chk("b2b_drained", out_valid, 0);
    chk("b2b_ready_back", issue_ready, 1);

    // Forced issue without credit.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      iss_x = 32'h0010_0000 * 32'(i + 3);
      iss_y = 32'(i);
      issue_valid = issue_ready;
      tick();
    end
    issue_valid = 1'b1;
    tick();
    issue_valid = 1'b0;
    chk("ovf_set", overflow_err, 1);
    chk("ovf_inflight", inflight, 4);
    repeat (35) tick();
    out_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) nv++;
      tick();
    end
    chk("ovf_entries", nv, 4);
    chk("ovf_sticky", overflow_err, 1);

    // Saturation on the gain=2.0 instance.
    single(32'h4000_0000, 32'hC000_0000, lat);
    chk("sat_latency", lat, 30);
`ifdef CORDIC_GAIN_COMP_EN
    chk("sat_cos_lit", s_cos, 32'h7FFF_FFFF);
    chk("sat_sin_lit", s_sin, 32'h8000_0000);
    chk("def_cos_lit", out_cos, 32'd652032768);
    chk("def_sin_lit", out_sin, 32'h0 - 32'd652032768);
`else
    chk("sat_cos_lit", s_cos, 32'h4000_0000);
    chk("sat_sin_lit", s_sin, 32'hC000_0000);
`endif
    repeat (3) tick();

    // Reset while three issues are in flight.
    for (int i = 0; i < 3; i++) begin
      iss_x = 32'h1234_0000 + 32'(i);
      iss_y = 32'h5678_0000 + 32'(i);
      issue_valid = 1'b1;
      tick();
    end
    issue_valid = 1'b0;
    repeat (15) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_inflight", inflight, 0);
    chk("mid_rst_ready", issue_ready, 1);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_overflow", overflow_err, 0);
    tick();
    rst = 1'b0;
    nv = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) nv++;
      tick();
    end
    chk("mid_rst_no_output", nv, 0);

    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
